led_serial_rx: RTL and testbench
================================

LED_SERIAL_RX -- requirements
Module: led_serial_rx

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 16, giving the frame width in bits (range 2..32).
REQ-002 The block SHALL have parameter DIR, default 0, where 0 means the first bit received is the MSB of the frame and 1 means it is the LSB.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 sclk  input  1  serial shift clock from the LED parallel-to-serial driver; data is valid at its rising edge.
REQ-006 sclrn  input  1  serial clear, active-low; empties the shift register.
REQ-007 sout  input  1  serial data bit.
REQ-008 EN  input  1  latch strobe; its rising edge ends a frame.
REQ-009 PData  output  DATA_BITS  last good frame received.
REQ-010 valid  output  1  one-clk pulse when PData updates.
REQ-011 frame_err  output  1  one-clk pulse when a frame is rejected.
REQ-012 bit_cnt  output  6  number of sclk rising edges since the last clear or strobe, saturating at 63.

Function
REQ-013 sclk, sclrn, sout and EN SHALL each pass through a 2-flop synchronizer on clk before any use.
REQ-014 Edge detection SHALL compare the synchronized value with a third registered copy of the same signal.
REQ-015 FSM states SHALL be IDLE, SHIFT and LATCH.
REQ-016 IDLE: a synchronized sclrn low SHALL clear the shift register and bit_cnt, with the FSM remaining in IDLE.
REQ-017 IDLE: a synchronized sclk rising edge while sclrn is high SHALL go to SHIFT and shift in the first bit.
REQ-018 SHIFT: on each sclk rising edge, the shift register SHALL take the synchronized sout value sampled on the same clk that the edge is detected.
REQ-019 Shift direction: DIR=0 SHALL shift left with the new bit entering bit 0; DIR=1 SHALL shift right with the new bit entering bit DATA_BITS-1.
REQ-020 SHIFT: each sclk rising edge SHALL increment bit_cnt by 1, saturating at 63.
REQ-021 SHIFT: sclrn low SHALL clear the shift register and bit_cnt and return the FSM to IDLE, with no valid and no frame_err.
REQ-022 SHIFT: an EN rising edge SHALL move the FSM to LATCH.
REQ-023 LATCH (one cycle): if bit_cnt == DATA_BITS, PData SHALL load the shift register and valid SHALL be 1 for that cycle.
REQ-024 LATCH (one cycle): otherwise PData SHALL hold and frame_err SHALL be 1 for that cycle.
REQ-025 LATCH (one cycle): bit_cnt SHALL clear and the FSM SHALL go to IDLE in either case.
REQ-026 An EN rising edge in IDLE with bit_cnt == 0 SHALL be ignored, producing no pulse.
REQ-027 If an sclk rising edge and an EN rising edge are detected on the same clk, the bit SHALL be shifted and counted first, and the latch decision SHALL use the updated count in the following LATCH cycle.
REQ-028 If sclrn low coincides with an EN rising edge, the clear SHALL take priority and the FSM SHALL go to IDLE with no pulse.
REQ-029 Latency: valid SHALL rise exactly 4 clk after the EN rising edge at the pin.
REQ-030 Latency breakdown: 2 clk synchronizer, 1 clk edge register, 1 clk LATCH.
REQ-031 valid and frame_err SHALL never be high on the same cycle.
REQ-032 Frames whose bits are not exactly DATA_BITS long (fewer, or more) SHALL be rejected via frame_err.

Reset
REQ-033 While rstn is low, the FSM SHALL be in IDLE and all outputs SHALL be 0: PData, valid, frame_err, bit_cnt.
REQ-034 While rstn is low, the shift register and all synchronizer flops SHALL be 0.
REQ-035 Reset assertion mid-frame SHALL discard the partial frame immediately, independent of clk.
REQ-036 After rstn deassertion, the block SHALL require a new sclk edge to begin a frame.

Structure
REQ-037 The shared package SHALL hold the FSM state encoding (IDLE=2'd0, SHIFT=2'd1, LATCH=2'd2) and the bit_cnt width constant 6.
REQ-038 The block SHALL use one sub-module, sync_edge, instantiated once per serial input: 2-flop synchronizer plus rise detector, outputs level and rise.

Verification
REQ-039 DATA_BITS=16, DIR=0: pulse sclrn low, send 16 bits of 16'hA5C3 MSB-first, then raise EN -> valid pulse 4 clk after EN, PData=16'hA5C3, frame_err=0.
REQ-040 DIR=1: send 16'h00FF LSB-first -> PData=16'h00FF, valid pulse; then send a second frame 16'h1234 -> PData=16'h1234.
REQ-041 Send 15 bits, then raise EN -> frame_err pulse, PData holds its previous value, bit_cnt back to 0.
REQ-042 Send 8 bits, drop sclrn for 3 clk, then send a full 16'hFFFF frame -> PData=16'hFFFF, valid, with no frame_err between.
REQ-043 Assert rstn low after bit 10 for 1 clk -> all outputs 0 immediately; following EN rise with no bits -> no pulse.
REQ-044 Drive sclk and EN edges on the same clk as the 16th bit -> valid pulse, PData correct, bit_cnt=16 seen before the clear.

Source files
------------

// File: rtl/led_serial_rx_pkg.sv
// led_serial_rx_pkg: shared FSM encoding and counter width for the LED serial receiver
package led_serial_rx_pkg;
  localparam int CNT_W = 6;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, LATCH = 2'd2} state_t;
endpackage

// File: rtl/led_serial_rx_if.sv
// led_serial_rx_if: serial link from the LED driver plus the received-frame outputs
interface led_serial_rx_if #(parameter int DATA_BITS = 16) ();
  import led_serial_rx_pkg::*;
  logic                 sclk;
  logic                 sclrn;
  logic                 sout;
  logic                 EN;
  logic [DATA_BITS-1:0] PData;
  logic                 valid;
  logic                 frame_err;
  logic [CNT_W-1:0]     bit_cnt;
  modport master (output sclk, sclrn, sout, EN, input PData, valid, frame_err, bit_cnt);
  modport slave  (input sclk, sclrn, sout, EN, output PData, valid, frame_err, bit_cnt);
endinterface

// File: rtl/led_serial_rx_sync_edge.sv
// sync_edge: 2-flop synchronizer with a third copy for rising-edge detection
module sync_edge (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic level,
  output logic rise
);
  logic [2:0] s;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) s <= '0;
    else       s <= {s[1:0], d};
  assign level = s[1];
  assign rise  = s[1] & ~s[2];
endmodule

// File: rtl/led_serial_rx.sv
// led_serial_rx: deserializes LED driver frames and latches them on the EN strobe
module led_serial_rx
  import led_serial_rx_pkg::*;
#(
  parameter int DATA_BITS = 16,
  parameter bit DIR       = 1'b0
) (
  input logic           clk,
  input logic           rstn,
  led_serial_rx_if.slave bus
);
  logic sclk_lvl, sclk_rise, clr_lvl, clr_rise, sout_lvl, sout_rise, en_lvl, en_rise, unused_ok;
  state_t state, state_d;
  logic [DATA_BITS-1:0] sr, sr_d, pdata, pdata_d, shifted;
  logic [CNT_W-1:0] cnt, cnt_d, cnt_inc;
  logic valid, valid_d, err, err_d, good;
  sync_edge u_sclk  (.clk, .rstn, .d(bus.sclk),  .level(sclk_lvl), .rise(sclk_rise));
  sync_edge u_sclrn (.clk, .rstn, .d(bus.sclrn), .level(clr_lvl),  .rise(clr_rise));
  sync_edge u_sout  (.clk, .rstn, .d(bus.sout),  .level(sout_lvl), .rise(sout_rise));
  sync_edge u_en    (.clk, .rstn, .d(bus.EN),    .level(en_lvl),   .rise(en_rise));
  assign unused_ok = &{1'b0, sclk_lvl, clr_rise, sout_rise, en_lvl};
  assign shifted = DIR ? {sout_lvl, sr[DATA_BITS-1:1]} : {sr[DATA_BITS-2:0], sout_lvl};
  assign cnt_inc = &cnt ? cnt : cnt + 1'b1;
  assign good    = cnt == CNT_W'(DATA_BITS);
  // A strobe arriving with the bit that completes the frame still latches it, using the updated count
  always_comb begin
    state_d = state;
    sr_d    = sr;
    cnt_d   = cnt;
    pdata_d = pdata;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state)
      IDLE, SHIFT: begin
        sr_d    = !clr_lvl ? '0 : sclk_rise ? shifted : sr;
        cnt_d   = !clr_lvl ? '0 : sclk_rise ? cnt_inc : cnt;
        state_d = !clr_lvl ? IDLE
                : en_rise && (sclk_rise || state == SHIFT) ? LATCH
                : sclk_rise ? SHIFT : state;
      end
      LATCH: begin
        pdata_d = good ? sr : pdata;
        valid_d = good;
        err_d   = !good;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
      pdata <= '0;
      valid <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_d;
      sr    <= sr_d;
      cnt   <= cnt_d;
      pdata <= pdata_d;
      valid <= valid_d;
      err   <= err_d;
    end
  assign bus.PData     = pdata;
  assign bus.valid     = valid;
  assign bus.frame_err = err;
  assign bus.bit_cnt   = cnt;
endmodule

// File: tb/tb_led_serial_rx.sv
// tb_led_serial_rx: directed and random frames into MSB-first and LSB-first receivers against a bit-list model
module tb_led_serial_rx;
  logic clk = 1'b0;
  logic rstn, sclk, sclrn, sout, en;
  int n_assert = 0;
  int n_fail   = 0;
  bit q[$];
  logic [15:0] exp0 = '0;
  logic [15:0] exp1 = '0;
  always #5 clk = ~clk;
  led_serial_rx_if #(.DATA_BITS(16)) if0 ();
  led_serial_rx_if #(.DATA_BITS(16)) if1 ();
  assign if0.sclk = sclk;
  assign if0.sclrn = sclrn;
  assign if0.sout = sout;
  assign if0.EN = en;
  assign if1.sclk = sclk;
  assign if1.sclrn = sclrn;
  assign if1.sout = sout;
  assign if1.EN = en;
  led_serial_rx #(.DATA_BITS(16), .DIR(1'b0)) dut0 (.clk(clk), .rstn(rstn), .bus(if0.slave));
  led_serial_rx #(.DATA_BITS(16), .DIR(1'b1)) dut1 (.clk(clk), .rstn(rstn), .bus(if1.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int sat_len();
    return (q.size() > 63) ? 63 : q.size();
  endfunction

  function automatic logic [15:0] assemble(input bit lsb_first);
    logic [15:0] v = '0;
    for (int i = 0; i < q.size(); i++)
      if (lsb_first) v = v | (16'(q[i]) << i);
      else v = v * 16'd2 + 16'(q[i]);
    return v;
  endfunction

  task automatic send_bit(input bit b);
    sout = b;
    repeat (3) @(negedge clk);
    sclk = 1'b1;
    q.push_back(b);
    repeat (3) @(negedge clk);
    chk("bit_cnt0", 32'(if0.bit_cnt), 32'(sat_len()));
    chk("bit_cnt1", 32'(if1.bit_cnt), 32'(sat_len()));
    sclk = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_bits(input logic [31:0] v, input int n, input bit lsb_first);
    for (int i = 0; i < n; i++) send_bit(lsb_first ? v[i] : v[n-1-i]);
  endtask

  task automatic do_clear();
    sclrn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("clr_pulse0", {if0.valid, if0.frame_err}, 0);
      chk("clr_pulse1", {if1.valid, if1.frame_err}, 0);
    end
    sclrn = 1'b1;
    repeat (3) @(negedge clk);
    q.delete();
    chk("clr_cnt0", 32'(if0.bit_cnt), 0);
    chk("clr_cnt1", 32'(if1.bit_cnt), 0);
  endtask

  task automatic latch(input bit with_bit, input bit b, input bit with_clr);
    bit good, bad;
    int cnt_exp;
    if (with_bit) begin
      sout = b;
      repeat (3) @(negedge clk);
      sclk = 1'b1;
      q.push_back(b);
    end
    en = 1'b1;
    if (with_clr) sclrn = 1'b0;
    good = !with_clr && q.size() == 16;
    bad = !with_clr && q.size() != 0 && !good;
    cnt_exp = with_clr ? 0 : sat_len();
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("valid0_k%0d", k), 32'(if0.valid), 32'(good && k == 4));
      chk($sformatf("valid1_k%0d", k), 32'(if1.valid), 32'(good && k == 4));
      chk($sformatf("err0_k%0d", k), 32'(if0.frame_err), 32'(bad && k == 4));
      chk($sformatf("err1_k%0d", k), 32'(if1.frame_err), 32'(bad && k == 4));
      if (k == 3) begin
        chk("latch_cnt0", 32'(if0.bit_cnt), 32'(cnt_exp));
        chk("latch_cnt1", 32'(if1.bit_cnt), 32'(cnt_exp));
      end
      if (k == 4) begin
        if (good) begin
          exp0 = assemble(1'b0);
          exp1 = assemble(1'b1);
        end
        chk("pdata0", 32'(if0.PData), 32'(exp0));
        chk("pdata1", 32'(if1.PData), 32'(exp1));
        chk("post_cnt0", 32'(if0.bit_cnt), 0);
        chk("post_cnt1", 32'(if1.bit_cnt), 0);
      end
    end
    sclk = 1'b0;
    en = 1'b0;
    sclrn = 1'b1;
    q.delete();
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int len, co;
    logic [31:0] v;
    rstn = 1'b0;
    sclk = 1'b0;
    sclrn = 1'b1;
    sout = 1'b0;
    en = 1'b0;
    #1;
    chk("rst_out0", {if0.PData, if0.valid, if0.frame_err, if0.bit_cnt}, 0);
    chk("rst_out1", {if1.PData, if1.valid, if1.frame_err, if1.bit_cnt}, 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    do_clear();
    send_bits(32'hA5C3, 16, 1'b0);
    latch(1'b0, 1'b0, 1'b0);
    chk("a5c3", 32'(if0.PData), 32'hA5C3);
    send_bits(32'h00FF, 16, 1'b1);
    latch(1'b0, 1'b0, 1'b0);
    chk("00ff", 32'(if1.PData), 32'h00FF);
    send_bits(32'h1234, 16, 1'b1);
    latch(1'b0, 1'b0, 1'b0);
    chk("1234", 32'(if1.PData), 32'h1234);
    send_bits(32'h5A5A, 15, 1'b0);
    latch(1'b0, 1'b0, 1'b0);
    send_bits(32'h00AB, 8, 1'b0);
    do_clear();
    send_bits(32'hFFFF, 16, 1'b0);
    latch(1'b0, 1'b0, 1'b0);
    chk("ffff", 32'(if0.PData), 32'hFFFF);
    send_bits(32'h3C96 >> 1, 15, 1'b0);
    latch(1'b1, 1'b0, 1'b0);
    chk("coincide", 32'(if0.PData), 32'h3C96);
    send_bits(32'h15, 5, 1'b0);
    latch(1'b0, 1'b0, 1'b1);
    send_bits(32'h2AAAAAAA, 30, 1'b0);
    send_bits(32'h35555555, 30, 1'b0);
    send_bits(32'h1F, 5, 1'b0);
    latch(1'b0, 1'b0, 1'b0);
    send_bits(32'h2B7, 10, 1'b0);
    rstn = 1'b0;
    #1;
    chk("midrst0", {if0.PData, if0.valid, if0.frame_err, if0.bit_cnt}, 0);
    chk("midrst1", {if1.PData, if1.valid, if1.frame_err, if1.bit_cnt}, 0);
    @(negedge clk);
    rstn = 1'b1;
    q.delete();
    exp0 = '0;
    exp1 = '0;
    repeat (3) @(negedge clk);
    latch(1'b0, 1'b0, 1'b0);
    for (int f = 0; f < 14; f++) begin
      case ($urandom_range(0, 3))
        0: len = 15;
        1: len = 16;
        2: len = 17;
        default: len = int'($urandom_range(1, 20));
      endcase
      co = int'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0) begin
        send_bits($urandom, int'($urandom_range(1, 8)), 1'b0);
        do_clear();
      end
      v = $urandom;
      send_bits(v, co != 0 ? len - 1 : len, 1'b0);
      latch(co != 0, v[31], 1'b0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
